// File: rtl/chan_pkg.sv
// Shared types for the corrupting-channel stage: mask-source modes, burst FSM states, LFSR taps.
// Pure declarations; no timing or flow-control behaviour of its own.
package chan_pkg;

  typedef enum logic [1:0] {CH_PASS, CH_PERIODIC, CH_BURST, CH_RANDOM} chan_mode_e;

  typedef enum logic {ST_COUNT, ST_BURST} burst_st_e;

  // Galois right-shift form of x^16+x^14+x^13+x^11+1
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [1:0] popcnt2(input logic [1:0] m);
    return {m[1] & m[0], m[1] ^ m[0]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR, advances one step per cycle with adv high, q is the current (pre-shift) state.
// Zero latency on q; holds when adv is low.
module lfsr16
  import chan_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        adv,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic [15:0] w_nxt;

  assign w_nxt = r_q[0] ? ((r_q >> 1) ^ LFSR_TAPS) : (r_q >> 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= SEED;
    end else if (adv) begin
      r_q <= w_nxt;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/channel_err_inj.sv
// Corrupting channel between convolutional encoder and Viterbi decoder: XORs periodic/burst/random masks.
// One-cycle registered symbol path with error statistics; never stalls, no backpressure.
module channel_err_inj
  import chan_pkg::*;
#(
  parameter int          PERIOD    = 16,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [1:0]       sym_i,
  input  logic [1:0]       mode_i,
  input  logic [1:0]       burst_len_i,
  input  logic [7:0]       thresh_i,
  input  logic             clr_i,
  output logic             valid_o,
  output logic [1:0]       sym_o,
  output logic             err_o,
  output logic [1:0]       err_bits_o,
  output logic [CNT_W-1:0] sym_cnt_o,
  output logic [CNT_W-1:0] bit_err_cnt_o
);

  localparam int              PC_W     = $clog2(PERIOD);
  localparam logic [PC_W-1:0] LAST_CNT = PC_W'(PERIOD - 1);

  chan_mode_e       r_mode_q;
  burst_st_e        r_st;
  logic [PC_W-1:0]  r_cnt;
  logic [1:0]       r_rem;
  logic             r_valid;
  logic [1:0]       r_sym;
  logic             r_err;
  logic [1:0]       r_err_bits;
  logic [CNT_W-1:0] r_sym_cnt;
  logic [CNT_W-1:0] r_bit_err_cnt;

  chan_mode_e       w_mode;
  logic             w_chg;
  logic [PC_W-1:0]  w_cnt_eff;
  burst_st_e        w_st_eff;
  logic             w_trig;
  logic [1:0]       w_len;
  logic [1:0]       w_mask;
  logic [PC_W-1:0]  w_cnt_nxt;
  burst_st_e        w_st_nxt;
  logic [1:0]       w_rem_nxt;
  logic [15:0]      w_lfsr;
  logic             w_lfsr_adv;
  logic [CNT_W:0]   w_bec_sum;

  // A mode switch restarts the period and burst tracking before the symbol is judged
  assign w_mode     = chan_mode_e'(mode_i);
  assign w_chg      = valid_i && (w_mode != r_mode_q);
  assign w_cnt_eff  = w_chg ? '0 : r_cnt;
  assign w_st_eff   = w_chg ? ST_COUNT : r_st;
  assign w_trig     = (w_cnt_eff == LAST_CNT);
  assign w_len      = (burst_len_i == 2'd0) ? 2'd1 : burst_len_i;
  assign w_lfsr_adv = valid_i && (w_mode == CH_RANDOM);

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .adv (w_lfsr_adv),
    .q   (w_lfsr)
  );

  always_comb begin
    w_mask    = 2'b00;
    w_cnt_nxt = r_cnt;
    w_st_nxt  = r_st;
    w_rem_nxt = r_rem;
    if (valid_i) begin
      w_cnt_nxt = w_cnt_eff;
      w_st_nxt  = w_st_eff;
      case (w_mode)
        CH_PERIODIC: begin
          if (w_trig) begin
            w_mask    = 2'b01;
            w_cnt_nxt = '0;
          end else begin
            w_cnt_nxt = w_cnt_eff + PC_W'(1);
          end
        end
        CH_BURST: begin
          if (w_trig) begin
            w_mask    = 2'b01;
            w_cnt_nxt = '0;
            w_rem_nxt = w_len - 2'd1;
            w_st_nxt  = (w_len > 2'd1) ? ST_BURST : ST_COUNT;
          end else begin
            w_cnt_nxt = w_cnt_eff + PC_W'(1);
            if (w_st_eff == ST_BURST) begin
              w_mask    = 2'b01;
              w_rem_nxt = r_rem - 2'd1;
              if (r_rem == 2'd1) begin
                w_st_nxt = ST_COUNT;
              end
            end
          end
        end
        CH_RANDOM: begin
          w_mask = {w_lfsr[15:8] < thresh_i, w_lfsr[7:0] < thresh_i};
        end
        default: begin
          w_mask = 2'b00;
        end
      endcase
    end
  end

  assign w_bec_sum = {1'b0, r_bit_err_cnt} + (CNT_W+1)'(popcnt2(w_mask));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode_q      <= CH_PASS;
      r_st          <= ST_COUNT;
      r_cnt         <= '0;
      r_rem         <= 2'd0;
      r_valid       <= 1'b0;
      r_sym         <= 2'b00;
      r_err         <= 1'b0;
      r_err_bits    <= 2'b00;
      r_sym_cnt     <= '0;
      r_bit_err_cnt <= '0;
    end else begin
      r_valid <= valid_i;
      r_cnt   <= w_cnt_nxt;
      r_st    <= w_st_nxt;
      r_rem   <= w_rem_nxt;
      if (valid_i) begin
        r_mode_q   <= w_mode;
        r_sym      <= sym_i ^ w_mask;
        r_err      <= |w_mask;
        r_err_bits <= w_mask;
      end else begin
        r_err      <= 1'b0;
        r_err_bits <= 2'b00;
      end
      if (clr_i) begin
        r_sym_cnt     <= '0;
        r_bit_err_cnt <= '0;
      end else if (valid_i) begin
        r_sym_cnt     <= r_sym_cnt + CNT_W'(1);
        r_bit_err_cnt <= w_bec_sum[CNT_W] ? '1 : w_bec_sum[CNT_W-1:0];
      end
    end
  end

  assign valid_o       = r_valid;
  assign sym_o         = r_sym;
  assign err_o         = r_err;
  assign err_bits_o    = r_err_bits;
  assign sym_cnt_o     = r_sym_cnt;
  assign bit_err_cnt_o = r_bit_err_cnt;

endmodule
